// File: rtl/lc3b_scoreboard_if.sv
// Decode/writeback bundle between the LC-3b issue stage and its register scoreboard.
interface lc3b_scoreboard_if;
    logic        issue_valid;
    logic [15:0] ir;
    logic        produces_dr;
    logic        need_sr1;
    logic        need_sr2;
    logic        need_Hsr;
    logic        wb_valid;
    logic [2:0]  wb_reg;
    logic        flush;
    logic        stall;
    logic        issue_ack;
    logic [7:0]  pending_mask;
    logic        busy;
    logic        underflow_err;

    modport master (
        output issue_valid, ir, produces_dr, need_sr1, need_sr2, need_Hsr,
        output wb_valid, wb_reg, flush,
        input  stall, issue_ack, pending_mask, busy, underflow_err
    );

    modport slave (
        input  issue_valid, ir, produces_dr, need_sr1, need_sr2, need_Hsr,
        input  wb_valid, wb_reg, flush,
        output stall, issue_ack, pending_mask, busy, underflow_err
    );
endinterface

// File: rtl/lc3b_scoreboard.sv
// Per-register in-flight writer counters for R0-R7 with RAW/saturation stall.
// Optional macro SB_LINK_R7_EN: JSR/JSRR/TRAP are treated as writers of R7.
module lc3b_scoreboard #(
    parameter int CNT_W = 2
) (
    input logic              clk,
    input logic              rst_n,
    lc3b_scoreboard_if.slave sb
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [7:0][CNT_W-1:0] cnt_q, cnt_d;
    logic                  underflow_q, underflow_d;
    logic [2:0]            dst;
    logic                  writes;
    logic                  src_hz, sat_hz, stall, ack;
    logic [7:0]            inc_v, dec_v, mask;
    logic                  unused_ir;

`ifdef SB_LINK_R7_EN
    logic is_link;
    assign is_link = (sb.ir[15:12] == 4'b0100) || (sb.ir[15:12] == 4'b1111);
    assign dst     = is_link ? 3'd7 : sb.ir[11:9];
    assign writes  = is_link || sb.produces_dr;
`else
    assign dst     = sb.ir[11:9];
    assign writes  = sb.produces_dr;
`endif
    assign unused_ir = ^{sb.ir[15:12], sb.ir[5:3]};

    // Hazards look only at current counts; a same-cycle writeback does not bypass.
    always_comb begin
        src_hz = (sb.need_sr1 && (cnt_q[sb.ir[8:6]]  != '0)) ||
                 (sb.need_sr2 && (cnt_q[sb.ir[2:0]]  != '0)) ||
                 (sb.need_Hsr && (cnt_q[sb.ir[11:9]] != '0));
        sat_hz = writes && (cnt_q[dst] == CNT_MAX);
        stall  = sb.issue_valid && (src_hz || sat_hz);
        ack    = sb.issue_valid && !stall && !sb.flush;
    end

    always_comb begin
        inc_v = '0;
        dec_v = '0;
        if (ack && writes) inc_v[dst]       = 1'b1;
        if (sb.wb_valid)   dec_v[sb.wb_reg] = 1'b1;
    end

    always_comb begin
        cnt_d       = cnt_q;
        underflow_d = underflow_q;
        if (sb.flush) begin
            cnt_d = '0;
        end else begin
            if (sb.wb_valid && (cnt_q[sb.wb_reg] == '0)) underflow_d = 1'b1;
            for (int i = 0; i < 8; i++) begin
                if (inc_v[i] && !dec_v[i])
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                else if (dec_v[i] && !inc_v[i] && (cnt_q[i] != '0))
                    cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            underflow_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            underflow_q <= underflow_d;
        end
    end

    always_comb begin
        mask = '0;
        for (int i = 0; i < 8; i++) mask[i] = (cnt_q[i] != '0);
    end

    assign sb.stall         = stall;
    assign sb.issue_ack     = ack;
    assign sb.pending_mask  = mask;
    assign sb.busy          = |mask;
    assign sb.underflow_err = underflow_q;
endmodule

// File: tb/tb_lc3b_scoreboard.sv
// Self-checking bench for lc3b_scoreboard: directed scenarios plus random traffic vs. a count model.
module tb_lc3b_scoreboard;
    localparam int CNT_W = 2;
    localparam int MAXC  = (1 << CNT_W) - 1;
`ifdef SB_LINK_R7_EN
    localparam bit LINK = 1'b1;
`else
    localparam bit LINK = 1'b0;
`endif

    logic clk;
    logic rst_n;
    lc3b_scoreboard_if sbi();

    lc3b_scoreboard #(.CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .sb(sbi));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;
    int mcnt[8];
    bit muf;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int m_dst();
        if (LINK && (sbi.ir[15:12] == 4'b0100 || sbi.ir[15:12] == 4'b1111)) return 7;
        return int'(sbi.ir[11:9]);
    endfunction

    function automatic bit m_writes();
        if (LINK && (sbi.ir[15:12] == 4'b0100 || sbi.ir[15:12] == 4'b1111)) return 1'b1;
        return sbi.produces_dr;
    endfunction

    function automatic bit m_stall();
        bit hz;
        if (!sbi.issue_valid) return 1'b0;
        hz = (sbi.need_sr1 && mcnt[sbi.ir[8:6]]  > 0) ||
             (sbi.need_sr2 && mcnt[sbi.ir[2:0]]  > 0) ||
             (sbi.need_Hsr && mcnt[sbi.ir[11:9]] > 0);
        return hz || (m_writes() && mcnt[m_dst()] == MAXC);
    endfunction

    function automatic bit m_ack();
        return sbi.issue_valid && !m_stall() && !sbi.flush;
    endfunction

    function automatic logic [7:0] m_mask();
        logic [7:0] m;
        for (int i = 0; i < 8; i++) m[i] = (mcnt[i] > 0);
        return m;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 8; i++) mcnt[i] = 0;
        muf = 1'b0;
    endtask

    // Apply one clock edge's worth of bookkeeping from the inputs that were held.
    task automatic m_update();
        int delta[8];
        if (!rst_n) return;
        if (sbi.flush) begin
            for (int i = 0; i < 8; i++) mcnt[i] = 0;
            return;
        end
        for (int i = 0; i < 8; i++) delta[i] = 0;
        if (m_ack() && m_writes()) delta[m_dst()]++;
        if (sbi.wb_valid) begin
            if (mcnt[sbi.wb_reg] == 0) muf = 1'b1;
            delta[sbi.wb_reg]--;
        end
        for (int i = 0; i < 8; i++) begin
            mcnt[i] = mcnt[i] + delta[i];
            if (mcnt[i] < 0) mcnt[i] = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        m_update();
    endtask

    task automatic set_in(input bit iv, input logic [15:0] ir, input bit pd, input bit s1,
                          input bit s2, input bit h, input bit wv, input logic [2:0] wr,
                          input bit fl);
        sbi.issue_valid = iv;
        sbi.ir          = ir;
        sbi.produces_dr = pd;
        sbi.need_sr1    = s1;
        sbi.need_sr2    = s2;
        sbi.need_Hsr    = h;
        sbi.wb_valid    = wv;
        sbi.wb_reg      = wr;
        sbi.flush       = fl;
    endtask

    task automatic idle();
        set_in(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            chk("cmp_stall",     {7'd0, sbi.stall},         {7'd0, m_stall()});
            chk("cmp_issue_ack", {7'd0, sbi.issue_ack},     {7'd0, m_ack()});
            chk("cmp_pending",   sbi.pending_mask,          m_mask());
            chk("cmp_busy",      {7'd0, sbi.busy},          {7'd0, (m_mask() != 8'h00)});
            chk("cmp_underflow", {7'd0, sbi.underflow_err}, {7'd0, muf});
        end
    end

    initial begin
        rst_n = 1'b0;
        idle();
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;
        #1;
        chk("rst_mask",  sbi.pending_mask, 8'h00);
        chk("rst_busy",  {7'd0, sbi.busy}, 8'h00);
        chk("rst_uf",    {7'd0, sbi.underflow_err}, 8'h00);
        chk("rst_stall", {7'd0, sbi.stall}, 8'h00);

        // RAW stall on R1, cleared by writeback one cycle later
        tick();
        set_in(1, 16'h1240, 1, 1, 1, 0, 0, 3'd0, 0); #1;
        chk("t1_ack0", {7'd0, sbi.issue_ack}, 8'h01);
        tick();
        set_in(1, 16'h1443, 1, 1, 1, 0, 1, 3'd1, 0); #1;
        chk("t1_stall", {7'd0, sbi.stall}, 8'h01);
        chk("t1_noack", {7'd0, sbi.issue_ack}, 8'h00);
        tick();
        set_in(1, 16'h1443, 1, 1, 1, 0, 0, 3'd0, 0); #1;
        chk("t1_nostall", {7'd0, sbi.stall}, 8'h00);
        chk("t1_ack1",    {7'd0, sbi.issue_ack}, 8'h01);
        tick();
        idle(); #1;
        chk("t1_mask", sbi.pending_mask, 8'h04);
        set_in(0, 16'h0000, 0, 0, 0, 0, 1, 3'd2, 0);
        tick();

        // Saturation of R3
        for (int k = 0; k < 3; k++) begin
            set_in(1, 16'h1600, 1, 0, 0, 0, 0, 3'd0, 0);
            tick();
        end
        #1;
        chk("t2_sat_stall", {7'd0, sbi.stall}, 8'h01);
        tick();
        set_in(1, 16'h1600, 1, 0, 0, 0, 1, 3'd3, 0); #1;
        chk("t2_sat_wb_stall", {7'd0, sbi.stall}, 8'h01);
        tick();
        set_in(1, 16'h1600, 1, 0, 0, 0, 0, 3'd0, 0); #1;
        chk("t2_fourth_ack", {7'd0, sbi.issue_ack}, 8'h01);
        tick();
        #1;
        chk("t2_full_again", {7'd0, sbi.stall}, 8'h01);
        for (int k = 0; k < 3; k++) begin
            set_in(0, 16'h0000, 0, 0, 0, 0, 1, 3'd3, 0);
            tick();
        end
        idle(); #1;
        chk("t2_drained", sbi.pending_mask, 8'h00);

        // Same-register issue + writeback on R5
        set_in(1, 16'h1A00, 1, 0, 0, 0, 0, 3'd0, 0);
        tick();
        set_in(1, 16'h1A00, 1, 0, 0, 0, 1, 3'd5, 0); #1;
        chk("t3_ack", {7'd0, sbi.issue_ack}, 8'h01);
        tick();
        idle(); #1;
        chk("t3_mask", sbi.pending_mask, 8'h20);
        set_in(0, 16'h0000, 0, 0, 0, 0, 1, 3'd5, 0);
        tick();
        idle(); #1;
        chk("t3_mask_clear", sbi.pending_mask, 8'h00);
        chk("t3_no_uf", {7'd0, sbi.underflow_err}, 8'h00);

        // Underflow, sticky through flush, cleared by async reset
        set_in(0, 16'h0000, 0, 0, 0, 0, 1, 3'd6, 0);
        tick();
        idle(); #1;
        chk("t4_uf_set",  {7'd0, sbi.underflow_err}, 8'h01);
        chk("t4_mask",    sbi.pending_mask, 8'h00);
        set_in(0, 16'h0000, 0, 0, 0, 0, 0, 3'd0, 1);
        tick();
        idle(); #1;
        chk("t4_uf_flush", {7'd0, sbi.underflow_err}, 8'h01);
        rst_n = 1'b0;
        m_reset();
        #1;
        chk("t4_uf_async", {7'd0, sbi.underflow_err}, 8'h00);
        tick();
        rst_n = 1'b1;

        // Flush with R1, R2, R4 pending and a competing issue
        set_in(1, 16'h1200, 1, 0, 0, 0, 0, 3'd0, 0); tick();
        set_in(1, 16'h1400, 1, 0, 0, 0, 0, 3'd0, 0); tick();
        set_in(1, 16'h1800, 1, 0, 0, 0, 0, 3'd0, 0); tick();
        idle(); #1;
        chk("t5_mask_pre", sbi.pending_mask, 8'h16);
        chk("t5_busy_pre", {7'd0, sbi.busy}, 8'h01);
        set_in(1, 16'h1600, 1, 0, 0, 0, 0, 3'd0, 1); #1;
        chk("t5_noack", {7'd0, sbi.issue_ack}, 8'h00);
        tick();
        idle(); #1;
        chk("t5_mask_post", sbi.pending_mask, 8'h00);
        chk("t5_busy_post", {7'd0, sbi.busy}, 8'h00);

        // JSR link to R7, then STR R7 reading it
        set_in(1, 16'h4802, 0, 0, 0, 0, 0, 3'd0, 0); #1;
        chk("t6_jsr_ack", {7'd0, sbi.issue_ack}, 8'h01);
        tick();
        idle(); #1;
        chk("t6_mask", sbi.pending_mask, LINK ? 8'h80 : 8'h00);
        set_in(1, 16'h7E80, 0, 1, 0, 1, 0, 3'd0, 0); #1;
        chk("t6_str_stall", {7'd0, sbi.stall}, LINK ? 8'h01 : 8'h00);
        if (LINK) begin
            set_in(1, 16'h7E80, 0, 1, 0, 1, 1, 3'd7, 0);
            tick();
            set_in(1, 16'h7E80, 0, 1, 0, 1, 0, 3'd0, 0); #1;
            chk("t6_str_go", {7'd0, sbi.issue_ack}, 8'h01);
        end
        tick();
        idle();

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            int pend[$];
            bit wv;
            logic [2:0] wr;
            pend.delete();
            for (int i = 0; i < 8; i++) if (mcnt[i] > 0) pend.push_back(i);
            wv = 1'b0;
            wr = 3'($urandom_range(0, 7));
            if (pend.size() > 0 && $urandom_range(0, 1) == 1) begin
                wv = 1'b1;
                wr = 3'(pend[$urandom_range(0, pend.size() - 1)]);
            end else if ($urandom_range(0, 15) == 0) begin
                wv = 1'b1;
            end
            set_in($urandom_range(0, 9) < 7, 16'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), 1'($urandom), wv, wr, $urandom_range(0, 63) == 0);
            tick();
        end
        idle();
        @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
